// File: rtl/maindec_mc2.sv
// -----------------------------------------------------------------------------
// maindec_mc2
//   Multicycle MIPS main controller FSM. Sequences FETCH/DECODE/execute/
//   write-back steps, drives the datapath mux selects and enables, talks to
//   memory through a req/ready handshake with wait states, and parks in a
//   sticky TRAP state on illegal opcodes or memory wait timeouts.
//
//   Memory handshake: mem_req is high in FETCH, MEMRD and MEMWR and its
//   address/data/strobe terms stay steady until the cycle in which
//   mem_ready is sampled high; that cycle completes the access and the FSM
//   moves on at the next rising edge. mem_ready outside those states is
//   ignored.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   opcode[5:0]       instr[31:26] from the instruction register
//   mem_ready         memory completes the current access this cycle
//   mem_req           memory access requested
//   pcwrite/branch/branchne/memwrite/irwrite/regwrite/iord/memtoreg/
//   regdst/alusrca/alusrcb/aluop/pcsrc   datapath controls
//   trap, trap_cause  sticky halt flag and cause (01 illegal, 10 timeout)
//   state_dbg[3:0]    current FSM state encoding
//   cyc_cnt, ret_cnt  performance counters (only with MAINDEC_PERF_EN)
//
// Configuration
//   MAINDEC_PERF_EN   adds cyc_cnt / ret_cnt counters and ports
// -----------------------------------------------------------------------------
module maindec_mc2 #(
    parameter int WAIT_TIMEOUT = 16,
    parameter int TO_CNT_W     = 8,
    parameter int PERF_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                pcwrite,
    output logic                branch,
    output logic                branchne,
    output logic                memwrite,
    output logic                irwrite,
    output logic                regwrite,
    output logic                iord,
    output logic                memtoreg,
    output logic                regdst,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [2:0]          aluop,
    output logic [1:0]          pcsrc,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [3:0]          state_dbg
`ifdef MAINDEC_PERF_EN
    ,
    output logic [PERF_W-1:0]   cyc_cnt,
    output logic [PERF_W-1:0]   ret_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR  = 4'd2,  S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_RTYPEEX = 4'd6,  S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,  S_BNEEX   = 4'd9,  S_ADDIEX  = 4'd10, S_ANDIEX  = 4'd11,
        S_ORIEX   = 4'd12, S_IMMWB   = 4'd13, S_JEX     = 4'd14, S_TRAP    = 4'd15
    } state_t;

    state_t              state_q, state_d;
    logic [TO_CNT_W-1:0] wait_q, wait_d, wait_inc;
    logic [1:0]          cause_q, cause_d;
    logic                timeout_hit;

    assign wait_inc = wait_q + TO_CNT_W'(1);
    // The wait cycle that would bring the count up to WAIT_TIMEOUT is the last
    // one tolerated; a mem_ready in that same cycle still completes normally.
    assign timeout_hit = (WAIT_TIMEOUT != 0) && (wait_inc == TO_CNT_W'(WAIT_TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        cause_d  = cause_q;
        mem_req  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        branchne = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 3'b000;
        pcsrc    = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                pcwrite = mem_ready;
                irwrite = mem_ready;
                if (mem_ready)        state_d = S_DECODE;
                else if (timeout_hit) begin state_d = S_TRAP; cause_d = 2'b10; end
                else                  wait_d = wait_inc;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_BNE:       state_d = S_BNEEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ANDI:      state_d = S_ANDIEX;
                    OP_ORI:       state_d = S_ORIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin state_d = S_TRAP; cause_d = 2'b01; end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready)        state_d = S_MEMWB;
                else if (timeout_hit) begin state_d = S_TRAP; cause_d = 2'b10; end
                else                  wait_d = wait_inc;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready)        state_d = S_FETCH;
                else if (timeout_hit) begin state_d = S_TRAP; cause_d = 2'b10; end
                else                  wait_d = wait_inc;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 3'b010;
                state_d = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQEX, S_BNEEX: begin
                alusrca  = 1'b1;
                aluop    = 3'b001;
                pcsrc    = 2'b01;
                branch   = (state_q == S_BEQEX);
                branchne = (state_q == S_BNEEX);
                state_d  = S_FETCH;
            end
            S_ADDIEX, S_ANDIEX, S_ORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = (state_q == S_ANDIEX) ? 3'b011 :
                          (state_q == S_ORIEX)  ? 3'b100 : 3'b000;
                state_d = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JEX: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // While reset is held the state is already FETCH, but the bus request
        // and the PC/IR load strobes must not act on a half-finished access.
        if (!reset) begin
            mem_req  = 1'b0;
            memwrite = 1'b0;
            pcwrite  = 1'b0;
            irwrite  = 1'b0;
        end
    end

    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign state_dbg  = state_q;

`ifdef MAINDEC_PERF_EN
    logic [PERF_W-1:0] cyc_q, cyc_d, ret_q, ret_d;

    always_comb begin
        cyc_d = cyc_q;
        ret_d = ret_q;
        if (state_q != S_TRAP) cyc_d = cyc_q + PERF_W'(1);
        // An instruction retires when control returns to FETCH.
        if (state_q != S_FETCH && state_d == S_FETCH) ret_d = ret_q + PERF_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    assign cyc_cnt = cyc_q;
    assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_maindec_mc2.sv
// -----------------------------------------------------------------------------
// tb_maindec_mc2
//   Directed bench for maindec_mc2 (WAIT_TIMEOUT=4). Inputs change on the
//   falling edge; outputs are checked 1 ns later, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_maindec_mc2;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3;
    localparam logic [3:0] MEMWB = 4'd4, MEMWR = 4'd5, BNEEX = 4'd9, ADDIEX = 4'd10;
    localparam logic [3:0] IMMWB = 4'd13, JEX = 4'd14, TRAP = 4'd15;

    localparam logic [5:0] OP_J = 6'b000010, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_req, pcwrite, branch, branchne, memwrite, irwrite, regwrite;
    logic       iord, memtoreg, regdst, alusrca, trap;
    logic [1:0] alusrcb, pcsrc, trap_cause;
    logic [2:0] aluop;
    logic [3:0] state_dbg;
`ifdef MAINDEC_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    maindec_mc2 #(.WAIT_TIMEOUT(4), .TO_CNT_W(8), .PERF_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .pcwrite(pcwrite), .branch(branch), .branchne(branchne),
        .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .iord(iord),
        .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .pcsrc(pcsrc), .trap(trap), .trap_cause(trap_cause),
        .state_dbg(state_dbg)
`ifdef MAINDEC_PERF_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; opcode = 6'd0; mem_ready = 1'b0;

        // reset state
        next_cyc(); #1;
        check("rst_state",   32'(state_dbg), 32'(FETCH));
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_pcwrite", 32'(pcwrite), 32'd0);
        check("rst_trap",    32'(trap), 32'd0);
        check("rst_cause",   32'(trap_cause), 32'd0);
        check("rst_alusrcb", 32'(alusrcb), 32'd1);

        // ADDI, zero wait
        next_cyc(); reset = 1'b1; opcode = OP_ADDI; mem_ready = 1'b1; #1;
        check("addi_f_state",   32'(state_dbg), 32'(FETCH));
        check("addi_f_pcwrite", 32'(pcwrite), 32'd1);
        check("addi_f_irwrite", 32'(irwrite), 32'd1);
        check("addi_f_mem_req", 32'(mem_req), 32'd1);
        check("addi_f_regw",    32'(regwrite), 32'd0);
        next_cyc(); #1;
        check("addi_d_state",   32'(state_dbg), 32'(DECODE));
        check("addi_d_alusrcb", 32'(alusrcb), 32'd3);
        check("addi_d_regw",    32'(regwrite), 32'd0);
        next_cyc(); #1;
        check("addi_x_state",   32'(state_dbg), 32'(ADDIEX));
        check("addi_x_aluop",   32'(aluop), 32'd0);
        check("addi_x_alusrca", 32'(alusrca), 32'd1);
        check("addi_x_alusrcb", 32'(alusrcb), 32'd2);
        check("addi_x_regw",    32'(regwrite), 32'd0);
        next_cyc(); #1;
        check("addi_wb_state",  32'(state_dbg), 32'(IMMWB));
        check("addi_wb_regw",   32'(regwrite), 32'd1);
        check("addi_wb_regdst", 32'(regdst), 32'd0);
        check("addi_wb_m2r",    32'(memtoreg), 32'd0);
        next_cyc(); #1;
        check("addi_end_state", 32'(state_dbg), 32'(FETCH));
        check("addi_end_regw",  32'(regwrite), 32'd0);
`ifdef MAINDEC_PERF_EN
        check("perf_cyc_addi", cyc_cnt, 32'd4);
        check("perf_ret_addi", ret_cnt, 32'd1);
`endif

        // LW with three wait cycles in MEMRD
        opcode = OP_LW;
        next_cyc(); #1;
        check("lw_d_state", 32'(state_dbg), 32'(DECODE));
        next_cyc(); #1;
        check("lw_a_state",   32'(state_dbg), 32'(MEMADR));
        check("lw_a_alusrca", 32'(alusrca), 32'd1);
        check("lw_a_alusrcb", 32'(alusrcb), 32'd2);
        next_cyc(); mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lw_wait_state", 32'(state_dbg), 32'(MEMRD));
            check("lw_wait_req",   32'(mem_req), 32'd1);
            check("lw_wait_iord",  32'(iord), 32'd1);
            next_cyc();
        end
        mem_ready = 1'b1; #1;
        check("lw_rdy_state", 32'(state_dbg), 32'(MEMRD));
        check("lw_rdy_iord",  32'(iord), 32'd1);
        next_cyc(); #1;
        check("lw_wb_state",  32'(state_dbg), 32'(MEMWB));
        check("lw_wb_regw",   32'(regwrite), 32'd1);
        check("lw_wb_m2r",    32'(memtoreg), 32'd1);
        check("lw_wb_regdst", 32'(regdst), 32'd0);
        check("lw_wb_req",    32'(mem_req), 32'd0);
        next_cyc(); #1;
        check("lw_end_state", 32'(state_dbg), 32'(FETCH));

        // BNE then J
        opcode = OP_BNE;
        next_cyc(); next_cyc(); #1;
        check("bne_state",    32'(state_dbg), 32'(BNEEX));
        check("bne_branchne", 32'(branchne), 32'd1);
        check("bne_branch",   32'(branch), 32'd0);
        check("bne_pcsrc",    32'(pcsrc), 32'd1);
        check("bne_aluop",    32'(aluop), 32'd1);
        check("bne_alusrcb",  32'(alusrcb), 32'd0);
        next_cyc(); #1;
        check("bne_end_state", 32'(state_dbg), 32'(FETCH));
        opcode = OP_J;
        next_cyc(); next_cyc(); #1;
        check("j_state",   32'(state_dbg), 32'(JEX));
        check("j_pcwrite", 32'(pcwrite), 32'd1);
        check("j_pcsrc",   32'(pcsrc), 32'd2);
        next_cyc(); #1;
        check("j_end_state", 32'(state_dbg), 32'(FETCH));

        // SW, zero wait
        opcode = OP_SW;
        next_cyc(); next_cyc(); next_cyc(); #1;
        check("sw_state",    32'(state_dbg), 32'(MEMWR));
        check("sw_memwrite", 32'(memwrite), 32'd1);
        check("sw_iord",     32'(iord), 32'd1);
        next_cyc(); #1;
        check("sw_end_state",    32'(state_dbg), 32'(FETCH));
        check("sw_end_memwrite", 32'(memwrite), 32'd0);

        // illegal opcode -> sticky TRAP
        opcode = OP_BAD;
        next_cyc(); next_cyc(); #1;
        check("ill_state", 32'(state_dbg), 32'(TRAP));
        check("ill_trap",  32'(trap), 32'd1);
        check("ill_cause", 32'(trap_cause), 32'd1);
        check("ill_req",   32'(mem_req), 32'd0);
        for (int i = 0; i < 20; i++) begin
            next_cyc(); #1;
            check("ill_hold", 32'({trap, trap_cause, state_dbg}), 32'({1'b1, 2'b01, TRAP}));
        end
        reset = 1'b0; #1;
        check("ill_rst_state", 32'(state_dbg), 32'(FETCH));
        check("ill_rst_trap",  32'(trap), 32'd0);
        check("ill_rst_cause", 32'(trap_cause), 32'd0);
        next_cyc(); reset = 1'b1; mem_ready = 1'b0; opcode = OP_ADDI;

        // fetch timeout after 4 wait cycles
        for (int i = 0; i < 4; i++) begin
            #1;
            check("to_wait_state",   32'(state_dbg), 32'(FETCH));
            check("to_wait_pcwrite", 32'(pcwrite), 32'd0);
            next_cyc();
        end
        #1;
        check("to_state",   32'(state_dbg), 32'(TRAP));
        check("to_cause",   32'(trap_cause), 32'd2);
        check("to_pcwrite", 32'(pcwrite), 32'd0);
        reset = 1'b0; next_cyc(); reset = 1'b1;

        // ready on the 4th wait cycle wins over timeout
        for (int i = 0; i < 3; i++) begin
            #1;
            check("to4_wait_state", 32'(state_dbg), 32'(FETCH));
            next_cyc();
        end
        mem_ready = 1'b1; #1;
        check("to4_rdy_pcwrite", 32'(pcwrite), 32'd1);
        next_cyc(); #1;
        check("to4_state", 32'(state_dbg), 32'(DECODE));
        check("to4_trap",  32'(trap), 32'd0);

        // reset during a stalled MEMWR
        reset = 1'b0; next_cyc(); reset = 1'b1; opcode = OP_SW; mem_ready = 1'b1;
        next_cyc(); next_cyc(); next_cyc(); mem_ready = 1'b0; #1;
        check("mwr_state",    32'(state_dbg), 32'(MEMWR));
        check("mwr_memwrite", 32'(memwrite), 32'd1);
        check("mwr_req",      32'(mem_req), 32'd1);
        next_cyc(); #1;
        check("mwr_hold_state", 32'(state_dbg), 32'(MEMWR));
        #2; reset = 1'b0; #1;
        check("mwr_rst_memwrite", 32'(memwrite), 32'd0);
        check("mwr_rst_req",      32'(mem_req), 32'd0);
        check("mwr_rst_state",    32'(state_dbg), 32'(FETCH));
`ifdef MAINDEC_PERF_EN
        check("perf_cyc_rst", cyc_cnt, 32'd0);
        check("perf_ret_rst", ret_cnt, 32'd0);
`endif
        next_cyc(); reset = 1'b1; #1;
        check("mwr_rel_state", 32'(state_dbg), 32'(FETCH));
        check("mwr_rel_req",   32'(mem_req), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
